jt49_bus_master: RTL and testbench

- Host-side sequencer that drives the BDIR/BC1/DA bus of a JT49 or an original AY-3-8910.
- Turns single-register write/read requests from a CPU-side valid/ready port into the two-phase PSG bus cycle: address latch, then data write or data read.
- Sits between a soft CPU/sequencer and either the jt49 bus wrapper (for simulation/on-chip) or the physical PSG pins (for external chips).
- All pin timing is in clock-enable ticks, so the same block serves fast and slow PSG clocks.

---
 rtl/jt49_pkg.sv | 41 ++++
 rtl/jt49_bus_master_timer.sv | 28 ++
 rtl/jt49_bus_master.sv | 156 +++++++++++++++
 tb/tb_jt49_bus_master.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt49_pkg.sv
// Shared definitions for the JT49 / AY-3-8910 host bus sequencer.
package jt49_pkg;

    localparam int TIMER_W = 4;

    // BDIR/BC1 bus codes as seen on the PSG pins
    localparam logic [1:0] BUS_INACT = 2'b00;
    localparam logic [1:0] BUS_READ  = 2'b01;
    localparam logic [1:0] BUS_WRITE = 2'b10;
    localparam logic [1:0] BUS_ADDR  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        A_SETUP,
        A_PULSE,
        A_HOLD,
        D_SETUP,
        D_PULSE,
        D_HOLD,
        DONE
    } state_t;

    // Bus code presented while sitting in a given state
    function automatic logic [1:0] bus_code(input state_t s, input logic we);
        logic [1:0] code;
        code = BUS_INACT;
        if (s == A_PULSE) code = BUS_ADDR;
        if (s == D_PULSE) code = we ? BUS_WRITE : BUS_READ;
        return code;
    endfunction

    // DA is driven for the whole address phase and for the data phase of writes
    function automatic logic drives_da(input state_t s, input logic we);
        logic oe;
        oe = 1'b0;
        if (s == A_SETUP || s == A_PULSE || s == A_HOLD) oe = 1'b1;
        if (s == D_SETUP || s == D_PULSE || s == D_HOLD) oe = we;
        return oe;
    endfunction

endpackage

// File: rtl/jt49_bus_master_timer.sv
// Phase timer: loads (T-1) on state entry, counts down on cen ticks.
module jt49_phase_timer
    import jt49_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cen,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic               expired
);

    logic [TIMER_W-1:0] count;

    // Load has priority; otherwise decrement on each tick until zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (cen && count != '0) begin
            count <= count - TIMER_W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/jt49_bus_master.sv
// Host-side sequencer turning single register requests into PSG
// BDIR/BC1/DA bus cycles (address latch, then data write or read).
module jt49_bus_master
    import jt49_pkg::*;
#(
    parameter int T_SETUP    = 1,
    parameter int T_PULSE    = 2,
    parameter int T_HOLD     = 1,
    parameter int ADDR_CACHE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic [3:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_done,
    output logic [7:0] rsp_rdata,
    input  logic       addr_inv,
    output logic       bdir,
    output logic       bc1,
    output logic [7:0] da_out,
    output logic       da_oe,
    input  logic [7:0] da_in
);

    // Handshake: a request transfers on any clk edge where req_valid and
    // req_ready are both high, independent of cen. req_ready is high in IDLE
    // and in the one-clk DONE state, so back-to-back requests lose no cycle.

    localparam logic [TIMER_W-1:0] LD_SETUP = TIMER_W'(T_SETUP - 1);
    localparam logic [TIMER_W-1:0] LD_PULSE = TIMER_W'(T_PULSE - 1);
    localparam logic [TIMER_W-1:0] LD_HOLD  = TIMER_W'(T_HOLD - 1);

    state_t             state;
    state_t             state_next;
    logic               accept;
    logic               hit;
    logic               step;
    logic               timer_expired;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_val;

    logic               cap_we;
    logic [3:0]         cap_addr;
    logic [7:0]         cap_wdata;
    logic               cur_we;
    logic [3:0]         cur_addr;
    logic [7:0]         cur_wdata;

    logic               cache_valid;
    logic [3:0]         cache_addr;

    assign accept = req_valid && req_ready;
    // An invalidation on the accept edge forces the address phase
    assign hit    = (ADDR_CACHE != 0) && cache_valid && !addr_inv && (cache_addr == req_addr);
    assign step   = cen && timer_expired;

    // Fields that apply to the state being entered: fresh on accept, captured otherwise
    assign cur_we    = accept ? req_we    : cap_we;
    assign cur_addr  = accept ? req_addr  : cap_addr;
    assign cur_wdata = accept ? req_wdata : cap_wdata;

    // Next-state selection; DONE leaves after one clk whatever cen does
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = hit ? D_SETUP : A_SETUP;
            A_SETUP: if (step) state_next = A_PULSE;
            A_PULSE: if (step) state_next = A_HOLD;
            A_HOLD:  if (step) state_next = D_SETUP;
            D_SETUP: if (step) state_next = D_PULSE;
            D_PULSE: if (step) state_next = D_HOLD;
            D_HOLD:  if (step) state_next = DONE;
            DONE:    state_next = accept ? (hit ? D_SETUP : A_SETUP) : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Reload the phase timer with the duration of whichever state is entered
    always_comb begin
        timer_load = (state_next != state);
        timer_val  = '0;
        unique case (state_next)
            A_SETUP, D_SETUP: timer_val = LD_SETUP;
            A_PULSE, D_PULSE: timer_val = LD_PULSE;
            A_HOLD,  D_HOLD:  timer_val = LD_HOLD;
            default:          timer_val = '0;
        endcase
    end

    jt49_phase_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .cen      (cen),
        .load     (timer_load),
        .load_val (timer_val),
        .expired  (timer_expired)
    );

    // Sequencer: state, request capture and all pin/response outputs registered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            bdir      <= 1'b0;
            bc1       <= 1'b0;
            da_out    <= '0;
            da_oe     <= 1'b0;
            req_ready <= 1'b1;
            rsp_done  <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                cap_we    <= req_we;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
            end
            {bdir, bc1} <= bus_code(state_next, cur_we);
            da_oe       <= drives_da(state_next, cur_we);
            // da_out only moves on phase entry; it keeps its value while undriven
            if (state_next != state) begin
                if (state_next == A_SETUP) begin
                    da_out <= {4'h0, cur_addr};
                end else if (state_next == D_SETUP && cur_we) begin
                    da_out <= cur_wdata;
                end
            end
            req_ready <= (state_next == IDLE) || (state_next == DONE);
            rsp_done  <= (state_next == DONE);
            // Sample the chip on the last tick of the read strobe
            if (state == D_PULSE && step && !cap_we) begin
                rsp_rdata <= da_in;
            end
        end
    end

    // Address cache: remembers the address latched by the last full A phase
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cache_valid <= 1'b0;
            cache_addr  <= '0;
        end else if (addr_inv) begin
            cache_valid <= 1'b0;
        end else if ((ADDR_CACHE != 0) && state == A_HOLD && state_next == D_SETUP) begin
            cache_valid <= 1'b1;
            cache_addr  <= cap_addr;
        end
    end

endmodule

// File: tb/tb_jt49_bus_master.sv
// Directed and randomized checks of the PSG bus sequencer against a
// transaction-level model and a loopback register-file stand-in for the chip.
module tb_jt49_bus_master;

    localparam int TS = 1;
    localparam int TP = 2;
    localparam int TH = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cen;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_done;
    logic [7:0] rsp_rdata;
    logic       addr_inv;
    logic       bdir;
    logic       bc1;
    logic [7:0] da_out;
    logic       da_oe;
    logic [7:0] da_in;

    int n_checks = 0;
    int n_fail   = 0;
    int div_cur  = 1;
    int ph       = 0;
    logic [1:0] prev_code = 2'b00;

    // Transaction-level model state
    logic       m_valid = 1'b0;
    logic [3:0] m_addr  = 4'h0;
    logic [7:0] m_last_dout = 8'h00;
    logic [7:0] m_rdata = 8'h00;
    logic [7:0] m_mem [16] = '{default: 8'h00};

    // Loopback chip stand-in
    logic [3:0] chip_addr = 4'h0;
    logic [7:0] chip_regs [16] = '{default: 8'h00};

    jt49_bus_master #(
        .T_SETUP    (TS),
        .T_PULSE    (TP),
        .T_HOLD     (TH),
        .ADDR_CACHE (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen       (cen),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_done  (rsp_done),
        .rsp_rdata (rsp_rdata),
        .addr_inv  (addr_inv),
        .bdir      (bdir),
        .bc1       (bc1),
        .da_out    (da_out),
        .da_oe     (da_oe),
        .da_in     (da_in)
    );

    always #5 clk = ~clk;

    // Chip stand-in: latch address on 11, store data on 10, return data on 01
    always @(posedge clk) begin
        if (bdir && bc1) chip_addr <= da_out[3:0];
        else if (bdir && !bc1) chip_regs[chip_addr] <= da_out;
    end
    assign da_in = chip_regs[chip_addr];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] obs();
        return {req_ready, rsp_done, da_oe, bdir, bc1, da_out};
    endfunction

    // One clk: cen for the coming edge, then sample just after it
    task automatic do_cycle();
        logic [1:0] cur;
        cen = (ph == 0);
        @(posedge clk);
        #1;
        ph  = (ph + 1 >= div_cur) ? 0 : ph + 1;
        cur = {bdir, bc1};
        chk("strobe_adjacency",
            32'(((prev_code == 2'b11) && (cur == 2'b10 || cur == 2'b01)) ||
                ((prev_code == 2'b10 || prev_code == 2'b01) && cur == 2'b11)), 0);
        prev_code = cur;
    endtask

    task automatic idle_check();
        req_valid = 1'b0;
        do_cycle();
        chk("idle_after_done", 32'({req_ready, rsp_done, bdir, bc1, da_oe}), 32'(5'b10000));
    endtask

    // One transaction; periods are counted from the accept edge, the DONE
    // period being the last one. Returns while sitting in the DONE period.
    task automatic run_txn(input logic we, input logic [3:0] addr, input logic [7:0] wdata,
                           input int div, input logic inv, input logic chained, input logic hold);
        logic [12:0] exp_q[$];
        logic        hit;
        logic [7:0]  dval;
        logic [1:0]  pc;
        int          lat;
        int          lat_exp;
        int          extra;
        logic        done_seen;

        hit = m_valid && (m_addr == addr) && !inv;
        if (!hit) begin
            repeat (TS * div) exp_q.push_back({3'b001, 2'b00, 4'h0, addr});
            repeat (TP * div) exp_q.push_back({3'b001, 2'b11, 4'h0, addr});
            repeat (TH * div) exp_q.push_back({3'b001, 2'b00, 4'h0, addr});
            m_last_dout = {4'h0, addr};
        end
        dval = we ? wdata : m_last_dout;
        pc   = we ? 2'b10 : 2'b01;
        repeat (TS * div) exp_q.push_back({2'b00, we, 2'b00, dval});
        repeat (TP * div) exp_q.push_back({2'b00, we, pc, dval});
        repeat (TH * div) exp_q.push_back({2'b00, we, 2'b00, dval});
        exp_q.push_back({2'b11, 1'b0, 2'b00, dval});
        m_last_dout = dval;
        lat_exp = (hit ? 1 : 2) * (TS + TP + TH) * div + 1;

        if (!chained) begin
            div_cur = div;
            ph      = 0;
        end
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        addr_inv  = inv;
        chk("ready_at_accept", 32'(req_ready), 1);
        do_cycle();
        addr_inv = 1'b0;
        if (!hold) req_valid = 1'b0;
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = 4'($urandom_range(0, 15));
        req_wdata = 8'($urandom_range(0, 255));

        lat = 0;
        done_seen = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            lat = i + 1;
            chk($sformatf("trace[%0d] a%0h", i, addr), 32'(obs()), 32'(exp_q[i]));
            if (rsp_done) begin
                done_seen = 1'b1;
                break;
            end
            if (i != exp_q.size() - 1) do_cycle();
        end
        extra = 0;
        while (!done_seen && extra < 100) begin
            do_cycle();
            lat++;
            extra++;
            if (rsp_done) done_seen = 1'b1;
        end
        chk("latency", lat, lat_exp);

        if (!hit) begin
            m_valid = 1'b1;
            m_addr  = addr;
        end
        if (we) begin
            m_mem[addr] = wdata;
            chk("rdata_kept", 32'(rsp_rdata), 32'(m_rdata));
        end else begin
            m_rdata = m_mem[addr];
            chk("rdata", 32'(rsp_rdata), 32'(m_rdata));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        cen       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 4'h0;
        req_wdata = 8'h00;
        addr_inv  = 1'b0;

        // Reset state
        repeat (3) do_cycle();
        chk("reset_outputs", 32'(obs()), 32'(13'h1000));
        chk("reset_rdata", 32'(rsp_rdata), 0);
        rst_n = 1'b1;
        idle_check();

        // Full write, then cached read of the same register
        run_txn(1'b1, 4'd7, 8'h38, 1, 1'b0, 1'b0, 1'b0);
        idle_check();
        run_txn(1'b0, 4'd7, 8'h00, 1, 1'b0, 1'b0, 1'b0);
        idle_check();
        chk("loopback_reg7", 32'(rsp_rdata), 32'(8'h38));

        // Slow ticks: one cen in four
        run_txn(1'b1, 4'd2, 8'h5A, 4, 1'b0, 1'b0, 1'b0);
        idle_check();

        // Invalidation on the accept edge of a same-address write
        run_txn(1'b1, 4'd2, 8'hA5, 1, 1'b1, 1'b0, 1'b0);
        idle_check();

        // Reset during the write strobe
        div_cur   = 1;
        ph        = 0;
        req_we    = 1'b1;
        req_addr  = 4'd9;
        req_wdata = 8'hC3;
        req_valid = 1'b1;
        do_cycle();
        req_valid = 1'b0;
        repeat (5) do_cycle();
        chk("abort_in_dpulse", 32'({bdir, bc1}), 32'(2'b10));
        rst_n = 1'b0;
        do_cycle();
        chk("abort_reset_outputs", 32'(obs()), 32'(13'h1000));
        chk("abort_reset_rdata", 32'(rsp_rdata), 0);
        rst_n = 1'b1;
        do_cycle();
        chk("abort_no_done", 32'({req_ready, rsp_done}), 32'(2'b10));
        m_valid     = 1'b0;
        m_last_dout = 8'h00;
        m_rdata     = 8'h00;
        run_txn(1'b1, 4'd9, 8'h96, 1, 1'b0, 1'b0, 1'b0);
        idle_check();

        // Back-to-back with req_valid held high, alternating addresses
        for (int k = 0; k < 6; k++) begin
            run_txn(1'($urandom_range(0, 1)), 4'(k % 2), 8'($urandom_range(0, 255)),
                    1, 1'b0, k > 0, k < 5);
        end
        idle_check();

        // Randomized mix of reads/writes, tick rates and invalidations
        for (int k = 0; k < 20; k++) begin
            run_txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
                    8'($urandom_range(0, 255)), $urandom_range(1, 3),
                    1'($urandom_range(0, 7) == 0), 1'b0, 1'b0);
            idle_check();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
